// File: rtl/wm_pkg.sv
// Shared watermarking defaults: block-mean / power-stage widths and FSM encodings.
package wm_pkg;

    localparam int MU_SIZE_DEF     = 10;
    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int BLOCK_LOG2_DEF  = 3;

    typedef enum logic {
        BM_ACCUM = 1'b0,
        BM_HOLD  = 1'b1
    } bm_state_e;

endpackage

// File: rtl/block_mean.sv
// Accumulates one N*N luminance block and emits its normalized mean mu_k.
// Define BLOCK_MEAN_ROUND_EN for round-half-up (saturating) instead of truncation.
module block_mean
    import wm_pkg::*;
#(
    parameter int MU_SIZE     = MU_SIZE_DEF,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int BLOCK_LOG2  = BLOCK_LOG2_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   pix_valid,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_ready,
    output logic                   mu_valid,
    input  logic                   mu_ready,
    output logic [MU_SIZE-1:0]     mu_k
);

    localparam int CW = 2 * BLOCK_LOG2;
    localparam int AW = PIXEL_WIDTH + CW;
    localparam int S  = AW - MU_SIZE;

    bm_state_e          state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [MU_SIZE-1:0] mu_q, mu_d;
    logic               last;
    logic [AW-1:0]      sum_nxt;
    logic [MU_SIZE-1:0] mu_calc;

    assign last    = (cnt_q == {CW{1'b1}});
    assign sum_nxt = acc_q + AW'(pix_data);

    // Scale the running sum including the pixel being accepted, so mu is ready on the last edge.
    generate
        if (S > 0) begin : g_shr
`ifdef BLOCK_MEAN_ROUND_EN
            localparam logic [AW:0] HALF = (AW+1)'(1) << (S - 1);
            logic [AW:0] rnd;
            assign rnd     = {1'b0, sum_nxt} + HALF;
            assign mu_calc = rnd[AW] ? {MU_SIZE{1'b1}} : MU_SIZE'(rnd >> S);
`else
            assign mu_calc = MU_SIZE'(sum_nxt >> S);
`endif
        end else if (S == 0) begin : g_eq
            assign mu_calc = sum_nxt;
        end else begin : g_shl
            localparam int LS = -S;
            assign mu_calc = {sum_nxt, {LS{1'b0}}};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mu_d    = mu_q;
        if (clr) begin
            state_d = BM_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            mu_d    = '0;
        end else if (state_q == BM_ACCUM) begin
            if (pix_valid) begin
                acc_d = sum_nxt;
                if (last) begin
                    state_d = BM_HOLD;
                    mu_d    = mu_calc;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else if (mu_ready) begin
            state_d = BM_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BM_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            mu_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mu_q    <= mu_d;
        end
    end

    assign pix_ready = (state_q == BM_ACCUM);
    assign mu_valid  = (state_q == BM_HOLD);
    assign mu_k      = mu_q;

endmodule

// File: tb/tb_block_mean.sv
// Directed and randomized checks of block_mean at default parameters.
module tb_block_mean;
    import wm_pkg::*;

    localparam int PW   = PIXEL_WIDTH_DEF;
    localparam int BL   = BLOCK_LOG2_DEF;
    localparam int MU   = MU_SIZE_DEF;
    localparam int NPIX = 1 << (2 * BL);
    localparam int SH   = PW + 2 * BL - MU;
`ifdef BLOCK_MEAN_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, clr, pix_valid, mu_ready;
    logic [PW-1:0] pix_data;
    logic          pix_ready, mu_valid;
    logic [MU-1:0] mu_k;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    always #5 clk = ~clk;

    block_mean dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .mu_valid  (mu_valid),
        .mu_ready  (mu_ready),
        .mu_k      (mu_k)
    );

    function automatic int ref_mu(input int sum);
        int r;
        r = sum;
        if (ROUND && SH > 0) r = sum + (1 << (SH - 1));
        r = (SH >= 0) ? (r >> SH) : (r << (-SH));
        if (r > (1 << MU) - 1) r = (1 << MU) - 1;
        return r;
    endfunction

    task automatic push_pix(input logic [PW-1:0] v);
        pix_valid = 1'b1;
        pix_data  = v;
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [PW-1:0] v);
        for (int i = 0; i < n; i++) push_pix(v);
    endtask

    task automatic pop_mu();
        mu_ready = 1'b1;
        @(posedge clk); #1;
        mu_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; pix_valid = 1'b0; mu_ready = 1'b0; pix_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({pix_ready, mu_valid, mu_k} !== {1'b1, 1'b0, {MU{1'b0}}})
            $display("FAIL reset_active: pix_ready=%b mu_valid=%b mu_k=%h, want 1 0 000", pix_ready, mu_valid, mu_k);
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({pix_ready, mu_valid, mu_k} !== {1'b1, 1'b0, {MU{1'b0}}})
            $display("FAIL reset_release: pix_ready=%b mu_valid=%b mu_k=%h, want 1 0 000", pix_ready, mu_valid, mu_k);
        else pass_cnt++;
    endtask

    task automatic test_zeros();
        push_n(NPIX - 1, 8'd0);
        total_cnt++;
        if (mu_valid !== 1'b0) $display("FAIL zeros_early: mu_valid=%b, want 0", mu_valid);
        else pass_cnt++;
        push_pix(8'd0);
        total_cnt++;
        if (mu_valid !== 1'b1 || mu_k !== 10'h000)
            $display("FAIL zeros_result: mu_valid=%b mu_k=%h, want 1 000", mu_valid, mu_k);
        else pass_cnt++;
        pop_mu();
        total_cnt++;
        if (mu_valid !== 1'b0 || pix_ready !== 1'b1)
            $display("FAIL zeros_release: mu_valid=%b pix_ready=%b, want 0 1", mu_valid, pix_ready);
        else pass_cnt++;
    endtask

    task automatic test_ones();
        push_n(NPIX, 8'd255);
        total_cnt++;
        if (mu_valid !== 1'b1 || mu_k !== 10'h3FC)
            $display("FAIL ones_result: mu_valid=%b mu_k=%h, want 1 3fc", mu_valid, mu_k);
        else pass_cnt++;
        pop_mu();
    endtask

    task automatic test_ramp_hold();
        for (int i = 0; i < NPIX; i++) push_pix(PW'(i));
        total_cnt++;
        if (mu_valid !== 1'b1 || mu_k !== 10'd126)
            $display("FAIL ramp_result: mu_valid=%b mu_k=%0d, want 1 126", mu_valid, mu_k);
        else pass_cnt++;
        pix_valid = 1'b1;
        pix_data  = 8'd200;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (mu_valid !== 1'b1 || pix_ready !== 1'b0 || mu_k !== 10'd126)
                $display("FAIL ramp_hold cyc %0d: mu_valid=%b pix_ready=%b mu_k=%0d, want 1 0 126", c, mu_valid, pix_ready, mu_k);
            else pass_cnt++;
        end
        pix_valid = 1'b0;
        pop_mu();
        total_cnt++;
        if (mu_valid !== 1'b0) $display("FAIL ramp_release: mu_valid=%b, want 0", mu_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (mu_valid !== 1'b0) $display("FAIL ramp_single_handshake: mu_valid=%b, want 0", mu_valid);
        else pass_cnt++;
        // Pixels offered during HOLD must not have been counted into the next block.
        push_n(NPIX - 1, 8'd0);
        total_cnt++;
        if (mu_valid !== 1'b0) $display("FAIL ramp_no_leak_early: mu_valid=%b, want 0", mu_valid);
        else pass_cnt++;
        push_pix(8'd0);
        total_cnt++;
        if (mu_valid !== 1'b1 || mu_k !== 10'h000)
            $display("FAIL ramp_no_leak_result: mu_valid=%b mu_k=%h, want 1 000", mu_valid, mu_k);
        else pass_cnt++;
        pop_mu();
    endtask

    task automatic test_clr();
        push_n(10, 8'd50);
        clr = 1'b1; pix_valid = 1'b1; pix_data = 8'd50;
        @(posedge clk); #1;
        clr = 1'b0; pix_valid = 1'b0;
        total_cnt++;
        if (pix_ready !== 1'b1 || mu_valid !== 1'b0)
            $display("FAIL clr_state: pix_ready=%b mu_valid=%b, want 1 0", pix_ready, mu_valid);
        else pass_cnt++;
        push_n(NPIX - 1, 8'd100);
        total_cnt++;
        if (mu_valid !== 1'b0) $display("FAIL clr_early: mu_valid=%b, want 0", mu_valid);
        else pass_cnt++;
        push_pix(8'd100);
        total_cnt++;
        if (mu_valid !== 1'b1 || mu_k !== 10'd400)
            $display("FAIL clr_result: mu_valid=%b mu_k=%0d, want 1 400", mu_valid, mu_k);
        else pass_cnt++;
        clr = 1'b1; mu_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; mu_ready = 1'b0;
        total_cnt++;
        if (mu_valid !== 1'b0 || pix_ready !== 1'b1)
            $display("FAIL clr_drop_hold: mu_valid=%b pix_ready=%b, want 0 1", mu_valid, pix_ready);
        else pass_cnt++;
    endtask

    task automatic test_rst_abort();
        push_n(10, 8'd50);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({pix_ready, mu_valid, mu_k} !== {1'b1, 1'b0, {MU{1'b0}}})
            $display("FAIL rst_mid_state: pix_ready=%b mu_valid=%b mu_k=%h, want 1 0 000", pix_ready, mu_valid, mu_k);
        else pass_cnt++;
        rst = 1'b1;
        push_n(NPIX - 1, 8'd100);
        total_cnt++;
        if (mu_valid !== 1'b0) $display("FAIL rst_early: mu_valid=%b, want 0", mu_valid);
        else pass_cnt++;
        push_pix(8'd100);
        total_cnt++;
        if (mu_valid !== 1'b1 || mu_k !== 10'd400)
            $display("FAIL rst_result: mu_valid=%b mu_k=%0d, want 1 400", mu_valid, mu_k);
        else pass_cnt++;
        pop_mu();
    endtask

    task automatic test_round();
        logic [MU-1:0] exp_mu;
        exp_mu = ROUND ? 10'd1 : 10'd0;
        push_n(NPIX - 1, 8'd0);
        push_pix(8'd8);
        total_cnt++;
        if (mu_valid !== 1'b1 || mu_k !== exp_mu)
            $display("FAIL round_result: mu_valid=%b mu_k=%0d, want 1 %0d", mu_valid, mu_k, exp_mu);
        else pass_cnt++;
        pop_mu();
    endtask

    task automatic test_random();
        int            q[$];
        int            sum = 0;
        int            cnt = 0;
        int            got = 0;
        int            cyc = 0;
        logic [PW-1:0] cur;
        cur = PW'($urandom);
        while (got < 100 && cyc < 60000) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_data  = cur;
            mu_ready  = ($urandom_range(0, 2) != 0);
            total_cnt++;
            if (mu_valid !== (q.size() != 0) || pix_ready !== (q.size() == 0))
                $display("FAIL random_state cyc %0d: mu_valid=%b pix_ready=%b, want %b %b", cyc, mu_valid, pix_ready, q.size() != 0, q.size() == 0);
            else pass_cnt++;
            if (pix_valid && pix_ready) begin
                sum += int'(cur);
                cnt++;
                cur = PW'($urandom);
                if (cnt == NPIX) begin
                    q.push_back(ref_mu(sum));
                    sum = 0;
                    cnt = 0;
                end
            end
            if (mu_valid && mu_ready) begin
                total_cnt++;
                if (q.size() == 0) $display("FAIL random_mu block %0d: mu_k=%0d, want no result", got, mu_k);
                else if (mu_k !== MU'(q[0])) $display("FAIL random_mu block %0d: mu_k=%0d, want %0d", got, mu_k, q[0]);
                else pass_cnt++;
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        pix_valid = 1'b0;
        mu_ready  = 1'b0;
        total_cnt++;
        if (got != 100) $display("FAIL random_blocks: got %0d blocks, want 100", got);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_ones();
        test_ramp_hold();
        test_clr();
        test_rst_abort();
        test_round();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/block_mean.md
BLOCK_MEAN -- requirements
Module: block_mean

Interface
REQ-001 Parameter MU_SIZE, default 10, SHALL set the width of the normalized block mean mu_k passed to the downstream power stage.
REQ-002 Parameter PIXEL_WIDTH, default 8, SHALL set the width of one luminance sample.
REQ-003 Parameter BLOCK_LOG2, default 3, SHALL set block side N = 2^BLOCK_LOG2, so each block holds N*N pixels (default 64).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 clr  input  1  SHALL be a synchronous clear that aborts a partial block.
REQ-007 pix_valid  input  1  SHALL mark pix_data as valid.
REQ-008 pix_data  input  PIXEL_WIDTH  SHALL carry one pixel, raster order within the block.
REQ-009 pix_ready  output  1  SHALL indicate the block can accept a pixel.
REQ-010 mu_valid  output  1  SHALL mark mu_k as a completed block mean.
REQ-011 mu_ready  input  1  SHALL indicate the downstream stage takes mu_k.
REQ-012 mu_k  output  MU_SIZE  SHALL carry the block mean as an unsigned fraction in [0,1), LSB = 2^-MU_SIZE.

Function
REQ-013 The FSM SHALL have two states: ACCUM (pix_ready=1, mu_valid=0) and HOLD (pix_ready=0, mu_valid=1).
REQ-014 In ACCUM, a pixel SHALL be accepted only when pix_valid and pix_ready are both 1 on a clock edge; the accumulator then adds pix_data and the pixel counter increments.
REQ-015 The accumulator SHALL be PIXEL_WIDTH+2*BLOCK_LOG2 bits wide, unsigned, and can never overflow.
REQ-016 On acceptance of pixel N*N-1, the FSM SHALL enter HOLD on that edge, with mu_k registered on the same edge (1-cycle latency from last pixel to mu_valid).
REQ-017 mu_k SHALL equal sum[PIXEL_WIDTH+2*BLOCK_LOG2-1 -: MU_SIZE] (truncation, shift S = PIXEL_WIDTH+2*BLOCK_LOG2-MU_SIZE); if S<0 the sum SHALL be left-shifted by -S.
REQ-018 In HOLD, mu_k and mu_valid SHALL be held stable until mu_ready=1; on that edge the FSM returns to ACCUM with accumulator and counter cleared.
REQ-019 The counter SHALL wrap from N*N-1 to 0 only via the HOLD->ACCUM transition; no pixel is accepted in HOLD.
REQ-020 clr=1 SHALL, on the next edge, clear accumulator and counter and enter ACCUM, dropping any held mu_k; clr has priority over a simultaneous pixel or mu handshake.
REQ-021 mu_valid SHALL not depend combinationally on mu_ready; pix_ready SHALL not depend combinationally on pix_valid.

Reset
REQ-022 While rst=0: state=ACCUM, accumulator=0, counter=0, mu_k=0, mu_valid=0, pix_ready=1 (after reset release); reset mid-block SHALL discard the partial block.

Configuration
REQ-023 With macro BLOCK_MEAN_ROUND_EN defined, mu_k SHALL be round-half-up: add 2^(S-1) before truncation, saturating to all ones on overflow (no-op when S<=0).
REQ-024 Without BLOCK_MEAN_ROUND_EN, mu_k SHALL be plain truncation per REQ-017 and no rounding adder is built.

Structure
REQ-025 Defaults for MU_SIZE, PIXEL_WIDTH, BLOCK_LOG2 and the FSM state encodings SHALL live in the shared watermarking package wm_pkg, used also by power_2 and its neighbours.
REQ-026 The block SHALL be one module with no sub-modules; the accumulator, counter and FSM are small enough to keep inline.

Verification
REQ-027 64 pixels of 0 -> mu_valid one cycle after last pixel, mu_k=0x000.
REQ-028 64 pixels of 255 -> sum 16320, mu_k=0x3FC (both macro settings).
REQ-029 Ramp 0..63 -> sum 2016, mu_k=126; then hold mu_ready=0 for 5 cycles -> mu_k stable, pix_ready=0 throughout, one mu handshake total.
REQ-030 10 pixels of 50, clr pulse, then 64 pixels of 100 -> single result mu_k=400; same sequence with rst pulled low instead of clr -> identical result.
REQ-031 63 pixels of 0 plus one pixel of 8 -> mu_k=0 without BLOCK_MEAN_ROUND_EN, mu_k=1 with it.
REQ-032 Random pix_valid gaps and random mu_ready over 100 blocks -> every mu_k matches the reference model, no pixel lost or duplicated.
